// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, baud codes
// (matching uart_byte_tx / uart_byte_rx) and the default watchdog limit.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_GAP
  } state_t;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  localparam int unsigned DEFAULT_TIMEOUT = 2000000;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin grant: combinational first-set scan starting at a registered
// pointer; the pointer moves to just past the last owner when told to.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic                       advance,
  input  logic [$clog2(N_REQ)-1:0]   last,
  output logic                       valid,
  output logic [$clog2(N_REQ)-1:0]   grant
);

  localparam int unsigned IW = $clog2(N_REQ);

  logic [IW-1:0] ptr;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (last == IW'(N_REQ - 1)) ? '0 : last + 1'b1;
    end
  end

  // Scan ptr, ptr+1, ... wrapping modulo N_REQ (not 2**IW).
  always_comb begin
    valid = 1'b0;
    grant = '0;
    sum   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (IW + 1)'(k);
      if (sum >= (IW + 1)'(N_REQ)) begin
        sum = sum - (IW + 1)'(N_REQ);
      end
      idx = sum[IW-1:0];
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_byte_tx between N_REQ requesters: round-robin grant, byte
// latch, send strobe, tx_done wait with watchdog, and inter-byte idle gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned GAP_W   = 16,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [8*N_REQ-1:0]         req_data,
  output logic [N_REQ-1:0]           req_ack,
  output logic [N_REQ-1:0]           req_done,
  output logic [N_REQ-1:0]           req_err,
  input  logic [2:0]                 cfg_baud,
  input  logic [GAP_W-1:0]           cfg_gap,
  output logic [7:0]                 tx_data,
  output logic                       tx_send_en,
  output logic [2:0]                 tx_baud,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   owner
);

  localparam int unsigned IW   = $clog2(N_REQ);
  localparam int unsigned WD_W = $clog2(TIMEOUT) + 1;

  state_t                  state;
  state_t                  state_next;
  logic [N_REQ-1:0][7:0]   bytes;
  logic                    grant_valid;
  logic [IW-1:0]           grant;
  logic [N_REQ-1:0]        grant_oh;
  logic [N_REQ-1:0]        owner_oh;
  logic [WD_W-1:0]         wd;
  logic                    wd_expire;
  logic [GAP_W-1:0]        gap_cnt;
  logic                    finish;

  assign bytes     = req_data;
  assign grant_oh  = N_REQ'(1) << grant;
  assign owner_oh  = N_REQ'(1) << owner;
  assign wd_expire = (wd == WD_W'(TIMEOUT - 1));
  assign busy      = (state != ST_IDLE);

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (finish),
    .last    (owner),
    .valid   (grant_valid),
    .grant   (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pulses are gated by reset so the strobe drops in the reset cycle itself.
  always_comb begin
    state_next = state;
    req_ack    = '0;
    req_done   = '0;
    req_err    = '0;
    tx_send_en = 1'b0;
    finish     = 1'b0;
    if (!reset) begin
      unique case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            req_ack    = grant_oh;
            state_next = ST_LOAD;
          end
        end
        ST_LOAD: state_next = ST_SEND;
        ST_SEND: begin
          tx_send_en = 1'b1;
          state_next = ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done) begin
            req_done   = owner_oh;
            finish     = 1'b1;
            state_next = ST_GAP;
          end else if (wd_expire) begin
            req_err    = owner_oh;
            finish     = 1'b1;
            state_next = ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner   <= '0;
      tx_data <= '0;
      tx_baud <= '0;
      wd      <= '0;
      gap_cnt <= '0;
    end else begin
      if (state == ST_IDLE) tx_baud <= cfg_baud;
      if (state == ST_IDLE && grant_valid) begin
        owner   <= grant;
        tx_data <= bytes[grant];
      end
      if (state == ST_SEND) begin
        wd <= '0;
      end else if (state == ST_WAIT) begin
        wd <= wd + 1'b1;
      end
      if (finish) begin
        gap_cnt <= cfg_gap;
      end else if (state == ST_GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

endmodule
